// File: rtl/alu_sequencer.sv
// Sequencer that feeds one operation at a time to an external 64-bit-result ALU,
// grants it a fixed number of cycles, then captures the result into z_hi/z_lo.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  output logic        ready,
  input  logic [4:0]  opcode,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

  state_t      r_state;
  logic [5:0]  r_count;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_op;
  logic [31:0] r_z_hi;
  logic [31:0] r_z_lo;
  logic        r_done;
  logic        r_err;
  logic        r_ready;

  logic        w_legal;
  logic        w_div_zero;
  logic        w_fail;
  logic [5:0]  w_load;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: w_legal = 1'b1;
      default:                                       w_legal = 1'b0;
    endcase
    w_div_zero = (opcode == OP_DIV) && (b_in == 32'd0);
    w_fail     = !w_legal || w_div_zero;
    if (opcode == OP_MUL)      w_load = MUL_LOAD;
    else if (opcode == OP_DIV) w_load = DIV_LOAD;
    else                       w_load = 6'd1;
  end

  // Handshake: start is accepted on a rising edge only while ready=1 (IDLE);
  // the operands are sampled at that edge and never need to be held afterwards.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_alu_op <= 5'd0;
      r_z_hi   <= 32'd0;
      r_z_lo   <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_alu_a  <= a_in;
            r_alu_b  <= b_in;
            r_alu_op <= opcode;
            r_ready  <= 1'b0;
            if (w_fail) begin
              // Rejected operations go straight to DONE and keep the old result.
              r_err   <= 1'b1;
              r_count <= 6'd0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_count <= w_load;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_count <= r_count - 6'd1;
          if (r_count == 6'd1) begin
            r_z_hi  <= alu_c[63:32];
            r_z_lo  <= alu_c[31:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign z_hi      = r_z_hi;
  assign z_lo      = r_z_lo;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one parameter, MUL_CYCLES, default 4: number of EXEC cycles granted to MUL (range 1-63).
REQ-002 The block SHALL have one parameter, DIV_CYCLES, default 8: number of EXEC cycles granted to DIV (range 1-63).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to run one operation.
REQ-006 The block SHALL have port ready, output, 1 bit: the sequencer is idle and accepts start.
REQ-007 The block SHALL have port opcode, input, 5 bits: the operation code.
REQ-008 The block SHALL have port a_in, input, 32 bits: operand A.
REQ-009 The block SHALL have port b_in, input, 32 bits: operand B.
REQ-010 The block SHALL have ports alu_a and alu_b, outputs, 32 bits each: registered operands driven to the ALU.
REQ-011 The block SHALL have port alu_op, output, 5 bits: registered opcode driven to the ALU.
REQ-012 The block SHALL have port alu_c, input, 64 bits: the ALU result.
REQ-013 The block SHALL have ports z_hi and z_lo, outputs, 32 bits each: result register, alu_c[63:32] and alu_c[31:0].
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port err, output, 1 bit: error flag of the last operation.

Function
REQ-016 Legal opcodes SHALL be: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010; all other values are illegal.
REQ-017 The FSM SHALL have the states IDLE, EXEC and DONE; ready SHALL be 1 only in IDLE.
REQ-018 In IDLE with start=1, the block SHALL latch a_in, b_in and opcode into alu_a, alu_b and alu_op at the edge, set err=0, and move to one of these:
- EXEC, with the cycle counter loaded with 1 (simple ops), MUL_CYCLES (MUL) or DIV_CYCLES (DIV).
- DONE, when the opcode is illegal or when DIV has b_in=0.
REQ-019 An illegal opcode, or DIV with b_in=0, SHALL skip EXEC, set err=1 and leave z_hi/z_lo unchanged.
REQ-020 In EXEC, the counter SHALL decrement each cycle; on the edge where the counter equals 1, the block SHALL capture alu_c into z_hi/z_lo and move to DONE.
REQ-021 Latency SHALL be measured from the start-accept edge to the first cycle of done=1; it SHALL be N+1 cycles, where N is the loaded count.
- Simple op: 2 cycles.
- MUL with default parameters: 5 cycles.
- Error path: 1 cycle.
REQ-022 done SHALL be 1 for exactly one cycle, in DONE; the next state SHALL always be IDLE.
REQ-023 start SHALL be ignored outside IDLE; a_in, b_in and opcode need not be held after acceptance.
REQ-024 alu_a, alu_b and alu_op SHALL stay constant from acceptance until the next acceptance.
REQ-025 z_hi, z_lo and err SHALL hold until the next capture or the next acceptance, respectively.
REQ-026 Back-to-back operations SHALL be supported: start held at 1 SHALL be accepted in every IDLE cycle, giving one operation per N+2 cycles.
REQ-027 The counter SHALL be 6 bits; a parameter value of 0 is illegal and its behaviour is undefined.

Reset
REQ-028 clear=0 SHALL, asynchronously and in any state including mid-EXEC, force:
- state = IDLE;
- counter, alu_a, alu_b, z_hi and z_lo = 0;
- alu_op = 00000;
- done = 0 and err = 0.
REQ-029 While clear=0, ready SHALL read 1; start SHALL be ignored while clear=0.
REQ-030 The first acceptance SHALL be possible on the first rising edge after clear rises.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- ADD with a_in=0x00000005, b_in=0x00000007, and the ALU model returning the sum -> done in cycle 2, z_lo=0x0000000C, z_hi=0, err=0.
- MUL with a_in=0xFFFFFFFF, b_in=0x00000002, default parameters -> ready=0 for 5 cycles, done in cycle 5, z_hi=0xFFFFFFFF, z_lo=0xFFFFFFFE.
- DIV with b_in=0 -> done in cycle 1, err=1, z_hi/z_lo keep their previous values, and alu_c is never captured.
- Opcode 11111 -> err=1, done in cycle 1; then ADD -> err returns to 0.
- clear pulsed low during the 3rd EXEC cycle of a MUL -> all outputs reset immediately, no done pulse, and a new SUB 9-4 completes with z_lo=5.
- start held high for 3 simple ops -> 3 done pulses spaced 3 cycles apart; start asserted during EXEC is ignored.
